keypad_entry: RTL

Scans a 4x4 matrix keypad, debounces it and assembles a two-digit decimal entry (00–99) for the 0-to-99 counter's load path. It is the input-side counterpart to the multiplexed 7-segment driver: that block strobes digit anodes outward, and this one strobes keypad rows and reads columns back. It sits beside the debouncer and feeds a one-cycle `load_pulse` plus the entered value to the counter logic.

---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_scan.sv | 156 +++++++++++++++
 rtl/keypad_entry.sv | 81 ++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, frame encoding and helper functions for the keypad entry block.
// Used by keypad_scan and keypad_entry (optional `#` commit feature: KEYPAD_ENTER_EN).
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    // Frame code: bit 4 set means exactly one key was seen, bits [3:0] hold its code.
    typedef logic [4:0] frame_t;
    localparam frame_t FRAME_NONE = 5'b0_0000;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_HELD     = 1'b1
    } deb_state_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // tens*10 computed as tens*8 + tens*2 so no multiplier is needed.
    function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
        logic [6:0] tens;
        tens = {3'b000, bcd[7:4]};
        return (tens << 3) + (tens << 1) + {3'b000, bcd[3:0]};
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row strobing, column synchronizer, per-frame key assembly with ghost rejection
// and press/release debounce. Emits a one-cycle key_valid with the accepted code.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RELEASED | no key accepted; counting identical single-key frames
// ST_HELD     | key accepted; counting frames without that key until release
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES      = 50000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk_50MHz,
    input  logic       reset_button,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int TW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam logic [TW-1:0] ROW_LAST = TW'(ROW_CYCLES - 1);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DEB_TC = CW'(DEBOUNCE_FRAMES);

    logic [3:0]    col_meta, col_sync;
    logic [TW-1:0] row_timer;
    logic [1:0]    row;
    logic [1:0]    hit_cnt;
    logic [3:0]    hit_code;
    frame_t        frame_code;
    logic          frame_done;
    logic          sample;

    logic [3:0] cols_down;
    logic [2:0] row_hits;
    logic [1:0] hit_col;
    logic [2:0] total;
    logic [3:0] cur_code;

    deb_state_t    state, state_nxt;
    logic [CW-1:0] deb_cnt, deb_cnt_nxt, cnt_inc;
    frame_t        cand, cand_nxt;
    logic          valid_nxt;
    logic [3:0]    code_nxt;

    assign sample = (row_timer == ROW_LAST);
    assign row_n  = ~(4'b0001 << row);

    always_comb begin
        cols_down = ~col_sync;
        row_hits  = '0;
        hit_col   = '0;
        for (int c = 0; c < 4; c++) begin
            if (cols_down[c]) begin
                row_hits = row_hits + 3'd1;
                hit_col  = 2'(c);
            end
        end
        total    = {1'b0, hit_cnt} + row_hits;
        cur_code = (row_hits == 3'd1) ? key_map(row, hit_col) : hit_code;
    end

    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            col_meta   <= 4'hF;
            col_sync   <= 4'hF;
            row_timer  <= '0;
            row        <= '0;
            hit_cnt    <= '0;
            hit_code   <= '0;
            frame_code <= FRAME_NONE;
            frame_done <= 1'b0;
        end else begin
            col_meta   <= col_n;
            col_sync   <= col_meta;
            frame_done <= 1'b0;
            if (sample) begin
                row_timer <= '0;
                row       <= row + 2'd1;
                if (row == 2'd3) begin
                    frame_done <= 1'b1;
                    frame_code <= (total == 3'd1) ? {1'b1, cur_code} : FRAME_NONE;
                    hit_cnt    <= '0;
                    hit_code   <= '0;
                end else begin
                    hit_cnt  <= (total >= 3'd2) ? 2'd2 : total[1:0];
                    hit_code <= cur_code;
                end
            end else begin
                row_timer <= row_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            state     <= ST_RELEASED;
            deb_cnt   <= '0;
            cand      <= FRAME_NONE;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_cnt_nxt;
            cand      <= cand_nxt;
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        cand_nxt    = cand;
        valid_nxt   = 1'b0;
        code_nxt    = key_code;
        cnt_inc     = deb_cnt + CW'(1);
        if (frame_done) begin
            case (state)
                ST_RELEASED: begin
                    if (frame_code[4]) begin
                        if (frame_code != cand) cnt_inc = CW'(1);
                        if (cnt_inc == DEB_TC) begin
                            valid_nxt   = 1'b1;
                            code_nxt    = frame_code[3:0];
                            state_nxt   = ST_HELD;
                            deb_cnt_nxt = '0;
                            cand_nxt    = FRAME_NONE;
                        end else begin
                            deb_cnt_nxt = cnt_inc;
                            cand_nxt    = frame_code;
                        end
                    end else begin
                        deb_cnt_nxt = '0;
                        cand_nxt    = FRAME_NONE;
                    end
                end
                ST_HELD: begin
                    // Any frame other than the held key counts toward release.
                    if (frame_code == {1'b1, key_code}) begin
                        deb_cnt_nxt = '0;
                    end else if (cnt_inc == DEB_TC) begin
                        state_nxt   = ST_RELEASED;
                        deb_cnt_nxt = '0;
                    end else begin
                        deb_cnt_nxt = cnt_inc;
                    end
                end
                default: state_nxt = ST_RELEASED;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Two-digit decimal entry from a scanned 4x4 keypad, with BCD and binary outputs.
// Define KEYPAD_ENTER_EN to commit with `#`; otherwise the second digit commits.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES      = 50000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk_50MHz,
    input  logic       reset_button,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] entry_bcd,
    output logic [6:0] entry_bin,
    output logic       load_pulse
);

    logic [1:0] digits_entered, de_nxt, de_sat;
    logic [7:0] bcd_nxt;
    logic       lp_nxt;

    keypad_scan #(
        .ROW_CYCLES      (ROW_CYCLES),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_scan (
        .clk_50MHz    (clk_50MHz),
        .reset_button (reset_button),
        .col_n        (col_n),
        .row_n        (row_n),
        .key_valid    (key_valid),
        .key_code     (key_code)
    );

    always_comb begin
        bcd_nxt = entry_bcd;
        de_nxt  = digits_entered;
        lp_nxt  = 1'b0;
        de_sat  = (digits_entered == 2'd2) ? 2'd2 : digits_entered + 2'd1;
        if (key_valid) begin
            if (key_code <= 4'd9) begin
                bcd_nxt = {entry_bcd[3:0], key_code};
`ifdef KEYPAD_ENTER_EN
                de_nxt  = de_sat;
`else
                if (de_sat == 2'd2) begin
                    lp_nxt = 1'b1;
                    de_nxt = 2'd0;
                end else begin
                    de_nxt = de_sat;
                end
`endif
            end else if (key_code == KEY_STAR) begin
                bcd_nxt = 8'h00;
                de_nxt  = 2'd0;
            end
`ifdef KEYPAD_ENTER_EN
            else if (key_code == KEY_HASH) begin
                lp_nxt = 1'b1;
                de_nxt = 2'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset_button) begin
        if (reset_button) begin
            entry_bcd      <= 8'h00;
            entry_bin      <= 7'd0;
            load_pulse     <= 1'b0;
            digits_entered <= 2'd0;
        end else begin
            entry_bcd      <= bcd_nxt;
            entry_bin      <= bcd_to_bin(bcd_nxt);
            load_pulse     <= lp_nxt;
            digits_entered <= de_nxt;
        end
    end

endmodule
